mp_addr_seq: RTL and testbench
==============================

// Module: mp_addr_seq
// PURPOSE
//  Parametrised, self-sequencing address unit for the mini-processor project.
//  Owns the program counter and instruction register. Runs a FETCH / RA / RB / EXEC / WB / RESULT
//  cycle against a req/ack memory bus, forming {page, group, index} addresses each state.
//  Sits between the top-level control and the shared register/instruction memory.
//  Unused page bits are driven with a defined page (PAGE_ALT), never X.
// PARAMETERS
//  ADDR_W    16      bus address width; must equal PAGE_W+GRP_W+IDX_W
//  PAGE_W    8       page field width (address MSBs)
//  GRP_W     4       group field width
//  IDX_W     4       index field width; also PC width, so program depth = 2**IDX_W
//  DATA_W    16      data/instruction width (>=12: op[11:8]=Rd, op[7:4]=Ra, op[3:0]=Rb)
//  PAGE_S0   8'h01   page used when s0_sel latched 1
//  PAGE_ALT  8'h00   page used when s0_sel latched 0
//  INST_GRP  4'h1    instruction group code
//  DATA_GRP  4'h0    data group code
//  IRQ_ADDR  16'h0122 interrupt register address (full address, ignores page)
//  HALT_OP   4'hF    op[DATA_W-1:DATA_W-4] value that ends the program
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  start       in   1       1-cycle pulse; begins a run from pc=0 (ignored unless IDLE)
//  s0_sel      in   1       page select, sampled on accepted start
//  bus_ack     in   1       memory completes current access this cycle
//  bus_rdata   in   DATA_W  read data, valid with bus_ack
//  alu_valid   in   1       ALU result ready (EXEC exit condition)
//  alu_result  in   DATA_W  value written to Rd in WB
//  w_Addr      out  ADDR_W  bus address
//  bus_req     out  1       access request, held until bus_ack
//  bus_we      out  1       1 = write (WB, RESULT), 0 = read
//  bus_wdata   out  DATA_W  write data
//  ra_q, rb_q  out  DATA_W  latched operands for the ALU
//  cur_op      out  DATA_W  instruction register
//  pc          out  IDX_W   program counter
//  busy        out  1       1 whenever state != IDLE
//  done        out  1       1-cycle pulse on RESULT ack
// BEHAVIOUR
//  Reset (any time, async): state=IDLE; pc, cur_op, ra_q, rb_q, w_Addr, bus_wdata=0;
//    bus_req, bus_we, done=0; page register=PAGE_ALT. A pending access is abandoned.
//  Outputs are registered. w_Addr, bus_req and bus_we change only on a state change and stay
//    stable while req=1. An access completes on the cycle bus_req && bus_ack. Ack with req=0 is ignored.
//  IDLE: on start, page <= s0_sel ? PAGE_S0 : PAGE_ALT; pc <= 0; go to FETCH.
//    Accepted start to first bus_req=1: 1 cycle.
//  FETCH: addr {page,INST_GRP,pc}, read. On ack: cur_op <= rdata; pc <= pc+1 (wraps mod 2**IDX_W).
//    If rdata top nibble == HALT_OP, go to RESULT; else go to RA.
//  RA: addr {page,DATA_GRP,op[7:4]}, read. On ack: ra_q <= rdata; go to RB.
//  RB: addr {page,DATA_GRP,op[3:0]}, read. On ack: rb_q <= rdata; go to EXEC.
//  EXEC: bus_req=0. Wait for alu_valid; then bus_wdata <= alu_result; go to WB.
//  WB: addr {page,DATA_GRP,op[11:8]}, write. On ack: if pc==0 (wrapped past last slot),
//    go to RESULT; else go to FETCH.
//  RESULT: addr IRQ_ADDR, write, wdata = {{DATA_W-IDX_W{1'b0}}, pc}. On ack: done=1 for 1 cycle;
//    go to IDLE.
//  An ack arriving in the same cycle the state is entered is valid. No minimum wait is imposed.
//  start while busy: ignored, no effect on state or page.
//  Illegal state encoding: next state is IDLE.
// TESTING
//  1 reset mid-RB with req=1 -> next cycle req=0, state IDLE, pc=0; a late ack is ignored.
//  2 s0_sel=1; start; mem[0x0110]=0x0312, mem[0x0101]=5, mem[0x0102]=7; alu_result=12
//    -> reads 0x0110, 0x0101, 0x0102; writes 12 to 0x0103; then fetches 0x0111.
//  3 s0_sel=0, same program -> same sequence with page 0x00, e.g. first fetch at 0x0010.
//  4 mem[0x0111]=0xF000 -> RESULT writes 0x0002 to 0x0122; done pulses once; busy drops the next cycle.
//  5 16 non-halt instructions -> pc wraps 15->0; after WB, RESULT writes 0 to 0x0122.
//  6 ack held low 10 cycles in FETCH -> w_Addr/req stable; start pulse meanwhile is ignored.

Source files
------------

// File: rtl/mp_addr_seq_if.sv
// ---------------------------------------------------------------------------
// mp_addr_seq_if
// Memory bus between the mini-processor address sequencer (master) and the
// shared register/instruction memory (slave).
//
// Signals:
//   w_Addr     master->slave  ADDR_W  bus address {page, group, index}
//   bus_req    master->slave  1       access request, held until bus_ack
//   bus_we     master->slave  1       1 = write, 0 = read
//   bus_wdata  master->slave  DATA_W  write data
//   bus_ack    slave->master  1       access completes this cycle (with req)
//   bus_rdata  slave->master  DATA_W  read data, valid with bus_ack
// ---------------------------------------------------------------------------
interface mp_addr_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] w_Addr;
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output w_Addr,
        output bus_req,
        output bus_we,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  w_Addr,
        input  bus_req,
        input  bus_we,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mp_addr_seq.sv
// ---------------------------------------------------------------------------
// mp_addr_seq
// Self-sequencing address unit of the mini-processor. Owns the program counter
// and instruction register and steps FETCH -> RA -> RB -> EXEC -> WB through a
// program, finishing with a RESULT write of the final pc to the interrupt
// register. Every bus access uses a {page, group, index} address; the page is
// chosen once per run from s0_sel.
//
// Ports:
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous active-high reset
//   start       in   1       run request, honoured only in IDLE
//   s0_sel      in   1       page select, sampled with an accepted start
//   bus         master       memory bus (see mp_addr_seq_if)
//   alu_valid   in   1       ALU result ready, ends EXEC
//   alu_result  in   DATA_W  value written back to Rd
//   ra_q, rb_q  out  DATA_W  latched ALU operands
//   cur_op      out  DATA_W  instruction register
//   pc          out  IDX_W   program counter
//   busy        out  1       high whenever not IDLE
//   done        out  1       one-cycle pulse after the RESULT write completes
//
// Instruction fields (IDX_W = 4): op[11:8] = Rd, op[7:4] = Ra, op[3:0] = Rb;
// the top nibble equal to HALT_OP ends the program.
// ---------------------------------------------------------------------------
module mp_addr_seq #(
    parameter int                 ADDR_W   = 16,
    parameter int                 PAGE_W   = 8,
    parameter int                 GRP_W    = 4,
    parameter int                 IDX_W    = 4,
    parameter int                 DATA_W   = 16,
    parameter logic [PAGE_W-1:0]  PAGE_S0  = 8'h01,
    parameter logic [PAGE_W-1:0]  PAGE_ALT = 8'h00,
    parameter logic [GRP_W-1:0]   INST_GRP = 4'h1,
    parameter logic [GRP_W-1:0]   DATA_GRP = 4'h0,
    parameter logic [ADDR_W-1:0]  IRQ_ADDR = 16'h0122,
    parameter logic [3:0]         HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               s0_sel,
    mp_addr_seq_if.master      bus,
    input  logic               alu_valid,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  ra_q,
    output logic [DATA_W-1:0]  rb_q,
    output logic [DATA_W-1:0]  cur_op,
    output logic [IDX_W-1:0]   pc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_RA     = 3'd2,
        S_RB     = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_RESULT = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [PAGE_W-1:0]   r_page;
    logic [IDX_W-1:0]    r_pc;
    logic [DATA_W-1:0]   r_op;
    logic [DATA_W-1:0]   r_ra;
    logic [DATA_W-1:0]   r_rb;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_req;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;

    logic                w_acc;
    logic                w_halt;
    logic                w_start_ok;
    logic                w_change;
    logic [PAGE_W-1:0]   w_page_nxt;
    logic [IDX_W-1:0]    w_pc_nxt;
    logic [DATA_W-1:0]   w_op_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_req_nxt;
    logic                w_we_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;

    // An ack without an outstanding request is not an access.
    assign w_acc      = r_req && bus.bus_ack;
    assign w_halt     = (bus.bus_rdata[DATA_W-1 -: 4] == HALT_OP);
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_change   = (w_state_nxt != r_state);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)     w_state_nxt = S_FETCH;
            S_FETCH:  if (w_acc)     w_state_nxt = w_halt ? S_RESULT : S_RA;
            S_RA:     if (w_acc)     w_state_nxt = S_RB;
            S_RB:     if (w_acc)     w_state_nxt = S_EXEC;
            S_EXEC:   if (alu_valid) w_state_nxt = S_WB;
            // pc back at 0 means the last program slot has just executed.
            S_WB:     if (w_acc)     w_state_nxt = (r_pc == '0) ? S_RESULT : S_FETCH;
            S_RESULT: if (w_acc)     w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Values that page/pc/op take at the coming edge. The bus outputs for
    // the next state are formed from these so that the first address of a
    // state already reflects a freshly fetched instruction or new pc.
    // ---------------------------------------------------------------------
    always_comb begin
        w_page_nxt = r_page;
        w_pc_nxt   = r_pc;
        w_op_nxt   = r_op;
        if (w_start_ok) begin
            w_page_nxt = s0_sel ? PAGE_S0 : PAGE_ALT;
            w_pc_nxt   = '0;
        end
        if ((r_state == S_FETCH) && w_acc) begin
            w_pc_nxt = r_pc + 1'b1;
            w_op_nxt = bus.bus_rdata;
        end
    end

    // ---------------------------------------------------------------------
    // Output logic: bus drive for the state being entered
    // ---------------------------------------------------------------------
    always_comb begin
        w_addr_nxt  = r_addr;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = r_wdata;
        case (w_state_nxt)
            S_FETCH: begin
                w_addr_nxt = {w_page_nxt, INST_GRP, w_pc_nxt};
                w_req_nxt  = 1'b1;
            end
            S_RA: begin
                w_addr_nxt = {w_page_nxt, DATA_GRP, w_op_nxt[IDX_W +: IDX_W]};
                w_req_nxt  = 1'b1;
            end
            S_RB: begin
                w_addr_nxt = {w_page_nxt, DATA_GRP, w_op_nxt[0 +: IDX_W]};
                w_req_nxt  = 1'b1;
            end
            S_WB: begin
                w_addr_nxt  = {w_page_nxt, DATA_GRP, w_op_nxt[2*IDX_W +: IDX_W]};
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = alu_result;
            end
            S_RESULT: begin
                w_addr_nxt  = IRQ_ADDR;
                w_req_nxt   = 1'b1;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = {{(DATA_W-IDX_W){1'b0}}, w_pc_nxt};
            end
            default: begin
                w_req_nxt = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Bus output registers: loaded only on a state change, so address,
    // request and direction stay put for as long as an access is pending.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_change) begin
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Program state and operand registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_page <= PAGE_ALT;
            r_pc   <= '0;
            r_op   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_done <= 1'b0;
        end else begin
            r_page <= w_page_nxt;
            r_pc   <= w_pc_nxt;
            r_op   <= w_op_nxt;
            if ((r_state == S_RA) && w_acc) begin
                r_ra <= bus.bus_rdata;
            end
            if ((r_state == S_RB) && w_acc) begin
                r_rb <= bus.bus_rdata;
            end
            r_done <= (r_state == S_RESULT) && w_acc;
        end
    end

    assign bus.w_Addr    = r_addr;
    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_wdata = r_wdata;

    assign ra_q   = r_ra;
    assign rb_q   = r_rb;
    assign cur_op = r_op;
    assign pc     = r_pc;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;

endmodule

// File: tb/tb_mp_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_mp_addr_seq
// Directed bench for mp_addr_seq: a zero-wait memory responder with a
// per-address stall, an access log, and hand-computed expected sequences.
// ---------------------------------------------------------------------------
module tb_mp_addr_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        s0_sel;
    logic        alu_valid;
    logic [15:0] alu_result;
    logic [15:0] ra_q;
    logic [15:0] rb_q;
    logic [15:0] cur_op;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    mp_addr_seq_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mp_addr_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s0_sel     (s0_sel),
        .bus        (bus),
        .alu_valid  (alu_valid),
        .alu_result (alu_result),
        .ra_q       (ra_q),
        .rb_q       (rb_q),
        .cur_op     (cur_op),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Memory model and responder
    logic [15:0] mem [0:65535];
    logic [15:0] hold_addr = 16'hFFFF;
    logic        resp_on   = 1'b1;
    logic        force_ack = 1'b0;
    bit          log_we   [$];
    logic [15:0] log_addr [$];
    logic [15:0] log_data [$];

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.bus_req && resp_on && (bus.w_Addr != hold_addr)) begin
                bus.bus_ack   = 1'b1;
                bus.bus_rdata = mem[bus.w_Addr];
                log_we.push_back(bus.bus_we);
                log_addr.push_back(bus.w_Addr);
                log_data.push_back(bus.bus_we ? bus.bus_wdata : mem[bus.w_Addr]);
                if (bus.bus_we) mem[bus.w_Addr] = bus.bus_wdata;
            end else begin
                bus.bus_ack   = force_ack;
                bus.bus_rdata = '0;
            end
        end
    end

    // done monitor
    int   done_total     = 0;
    logic done_busy      = 1'b1;
    logic done_prev_busy = 1'b0;
    logic prev_busy      = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_total++;
                done_busy      = busy;
                done_prev_busy = prev_busy;
            end
            prev_busy = busy;
        end
    end

    int log_base;
    int done_base;

    task automatic start_run(input logic sel);
        @(negedge clk);
        log_base  = log_addr.size();
        done_base = done_total;
        s0_sel = sel;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((done_total == done_base) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_val({tag, "_done_seen"}, 32'(done_total != done_base), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check_val({tag, "_done_once"}, 32'(done_total - done_base), 32'd1);
    endtask

    task automatic chk_acc(input string tag, input int k, input bit we,
                           input logic [15:0] addr, input logic [15:0] data);
        int idx = log_base + k;
        if (idx >= log_addr.size()) begin
            check_val({tag, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
        end else begin
            check_val({tag, "_acc"}, {15'd0, log_we[idx], log_addr[idx]}, {15'd0, we, addr});
            check_val({tag, "_data"}, {16'd0, log_data[idx]}, {16'd0, data});
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        reset      = 1'b1;
        start      = 1'b0;
        s0_sel     = 1'b0;
        alu_valid  = 1'b1;
        alu_result = 16'd12;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy",  {31'd0, busy}, 32'd0);
        check_val("rst_req",   {31'd0, bus.bus_req}, 32'd0);
        check_val("rst_we",    {31'd0, bus.bus_we}, 32'd0);
        check_val("rst_done",  {31'd0, done}, 32'd0);
        check_val("rst_pc",    {28'd0, pc}, 32'd0);
        check_val("rst_addr",  {16'd0, bus.w_Addr}, 32'd0);
        check_val("rst_op",    {16'd0, cur_op}, 32'd0);
        check_val("rst_wdata", {16'd0, bus.bus_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Program used by several runs (page 1 and page 0 copies)
        mem[16'h0110] = 16'h0312; mem[16'h0101] = 16'd5; mem[16'h0102] = 16'd7;
        mem[16'h0111] = 16'hF000;
        mem[16'h0010] = 16'h0312; mem[16'h0001] = 16'd5; mem[16'h0002] = 16'd7;
        mem[16'h0011] = 16'hF000;

        // Reset in the middle of an RB access
        begin
            bit found = 1'b0;
            hold_addr = 16'h0102;
            start_run(1'b1);
            for (int n = 0; n < 20 && !found; n++) begin
                if (bus.bus_req && bus.w_Addr == 16'h0102) found = 1'b1;
                else begin @(negedge clk); #1; end
            end
            check_val("t1_reach_rb", {31'd0, found}, 32'd1);
            check_val("t1_ra_q", {16'd0, ra_q}, 32'd5);
            reset = 1'b1;
            #1;
            check_val("t1_req_after_rst", {31'd0, bus.bus_req}, 32'd0);
            check_val("t1_busy_after_rst", {31'd0, busy}, 32'd0);
            check_val("t1_pc_after_rst", {28'd0, pc}, 32'd0);
            check_val("t1_ra_after_rst", {16'd0, ra_q}, 32'd0);
            @(negedge clk);
            reset     = 1'b0;
            hold_addr = 16'hFFFF;
            resp_on   = 1'b0;
            force_ack = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            check_val("t1_late_ack_busy", {31'd0, busy}, 32'd0);
            check_val("t1_late_ack_req", {31'd0, bus.bus_req}, 32'd0);
            check_val("t1_late_ack_pc", {28'd0, pc}, 32'd0);
            check_val("t1_late_ack_done", 32'(done_total), 32'd0);
            force_ack = 1'b0;
            resp_on   = 1'b1;
            repeat (2) @(negedge clk);
        end

        // Page 1 run, halts on the second instruction
        start_run(1'b1);
        check_val("t2_first_req", {15'd0, bus.bus_req, bus.w_Addr}, {15'd0, 1'b1, 16'h0110});
        wait_done("t2", 100);
        chk_acc("t2_k0", 0, 1'b0, 16'h0110, 16'h0312);
        chk_acc("t2_k1", 1, 1'b0, 16'h0101, 16'h0005);
        chk_acc("t2_k2", 2, 1'b0, 16'h0102, 16'h0007);
        chk_acc("t2_k3", 3, 1'b1, 16'h0103, 16'h000C);
        chk_acc("t2_k4", 4, 1'b0, 16'h0111, 16'hF000);
        chk_acc("t2_k5", 5, 1'b1, 16'h0122, 16'h0002);
        check_val("t2_nacc", 32'(log_addr.size() - log_base), 32'd6);
        check_val("t2_ra_rb", {ra_q, rb_q}, {16'd5, 16'd7});
        check_val("t2_cur_op", {16'd0, cur_op}, 32'h0000F000);
        check_val("t2_pc", {28'd0, pc}, 32'd2);
        check_val("t2_busy_at_done", {31'd0, done_busy}, 32'd0);
        check_val("t2_busy_before_done", {31'd0, done_prev_busy}, 32'd1);

        // Page 0 run of the same program
        start_run(1'b0);
        check_val("t3_first_req", {15'd0, bus.bus_req, bus.w_Addr}, {15'd0, 1'b1, 16'h0010});
        wait_done("t3", 100);
        chk_acc("t3_k0", 0, 1'b0, 16'h0010, 16'h0312);
        chk_acc("t3_k1", 1, 1'b0, 16'h0001, 16'h0005);
        chk_acc("t3_k2", 2, 1'b0, 16'h0002, 16'h0007);
        chk_acc("t3_k3", 3, 1'b1, 16'h0003, 16'h000C);
        chk_acc("t3_k4", 4, 1'b0, 16'h0011, 16'hF000);
        chk_acc("t3_k5", 5, 1'b1, 16'h0122, 16'h0002);

        // Sixteen non-halting instructions: pc wraps, RESULT reports 0
        for (int i = 0; i < 16; i++) mem[16'h0110 + i] = 16'h0312;
        alu_result = 16'h00A5;
        start_run(1'b1);
        wait_done("t5", 400);
        check_val("t5_nacc", 32'(log_addr.size() - log_base), 32'd65);
        chk_acc("t5_k4",  4,  1'b0, 16'h0111, 16'h0312);
        chk_acc("t5_k60", 60, 1'b0, 16'h011F, 16'h0312);
        chk_acc("t5_k63", 63, 1'b1, 16'h0103, 16'h00A5);
        chk_acc("t5_k64", 64, 1'b1, 16'h0122, 16'h0000);
        check_val("t5_pc", {28'd0, pc}, 32'd0);

        // FETCH stalled for 10 cycles; a start pulse meanwhile is ignored
        mem[16'h0111] = 16'hF000;
        alu_result    = 16'd12;
        hold_addr     = 16'h0110;
        start_run(1'b1);
        for (int c = 0; c < 10; c++) begin
            check_val($sformatf("t6_stable_c%0d", c), {15'd0, bus.bus_req, bus.w_Addr},
                      {15'd0, 1'b1, 16'h0110});
            @(negedge clk);
            if (c == 3) begin
                s0_sel = 1'b0;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            #1;
        end
        start = 1'b0;
        check_val("t6_pc_stalled", {28'd0, pc}, 32'd0);
        hold_addr = 16'hFFFF;
        wait_done("t6", 100);
        chk_acc("t6_k0", 0, 1'b0, 16'h0110, 16'h0312);
        chk_acc("t6_k1", 1, 1'b0, 16'h0101, 16'h0005);
        chk_acc("t6_k5", 5, 1'b1, 16'h0122, 16'h0002);
        check_val("t6_nacc", 32'(log_addr.size() - log_base), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
